instr_cache_ctrl: RTL and testbench
===================================

Name: instr_cache_ctrl

Overview:
Direct-mapped instruction cache with refill controller. It is the responder for the fetch stage's instruction lookup: fetch drives PC and receives a combinational instruction plus a stall indication on hit or miss. On a miss it runs a request/grant/beat refill burst to backing memory, installs the line and releases the stall.

Parameters:
LINE_WORDS, 4, 32-bit words per line (power of 2, >=2)
NUM_LINES, 16, number of lines (power of 2, >=2)
NOP_INSTR, 32'h00000013, instruction driven while stalled (addi x0,x0,0)

Ports:
CLK  input  1  clock, all state on posedge
RESET  input  1  synchronous, active-low reset
PC  input  64  fetch address from fetch stage
IC_FLUSH  input  1  invalidate all lines (fence.i)
instruction  output  32  instruction at PC; NOP_INSTR when IC_STALL=1
IC_STALL  output  1  1 = instruction not valid, fetch must hold PC
MEM_REQ  output  1  refill request, held until grant
MEM_ADDR  output  64  line-aligned refill address
MEM_GNT  input  1  memory accepts request
MEM_RVALID  input  1  one refill data beat valid
MEM_RDATA  input  32  refill beat data, offset 0 first

Behaviour:
- Address split: OFF=log2(LINE_WORDS)+2 bits PC[OFF-1:0]. PC[1:0] ignored. Index IDX=log2(NUM_LINES) bits above the offset. Tag = PC[63:OFF+IDX].
- Storage: valid[NUM_LINES], tag array, data array [NUM_LINES][LINE_WORDS] x 32, all flops. Reads are combinational.
- hit = state==IDLE && valid[idx] && tag[idx]==PC tag. IC_STALL = !hit. instruction = hit ? data[idx][word] : NOP_INSTR.
- FSM states: IDLE, REQ, FILL, DONE.
- IDLE:
  - On miss, latch line address {PC[63:OFF], OFF'b0} into miss_addr and go to REQ.
  - If IC_FLUSH is also asserted that cycle, the flush still clears all valid bits.
- REQ:
  - MEM_REQ=1 and MEM_ADDR=miss_addr.
  - When MEM_GNT=1, go to FILL and set beat counter=0.
  - MEM_REQ drops the cycle after the grant.
- FILL:
  - Each MEM_RVALID=1 cycle writes MEM_RDATA to data[miss_idx][beat] and increments beat.
  - Gaps (MEM_RVALID=0) are allowed.
  - On the beat with beat==LINE_WORDS-1, go to DONE.
- DONE:
  - Write tag[miss_idx]. Set valid[miss_idx]=1 unless discard=1.
  - Clear discard and go to IDLE.
  - IC_STALL stays 1 in DONE. The hit is re-evaluated against the current PC in the following IDLE cycle; a different PC may miss again.
- MEM_RVALID outside FILL is ignored. MEM_GNT outside REQ is ignored.
- Miss penalty with grant in the first REQ cycle and back-to-back beats: IC_STALL=1 for LINE_WORDS+3 cycles (miss cycle, REQ, LINE_WORDS x FILL, DONE). The hit occurs on the next cycle.
- IC_FLUSH:
  - Clears all valid bits next edge, in any state.
  - If asserted in REQ, FILL or DONE, it sets discard, so the in-flight line is written but not marked valid.
  - The burst always completes; there is no abort.
- Reset (RESET=0):
  - state=IDLE, all valid=0, discard=0, beat=0, MEM_REQ=0, MEM_ADDR=0.
  - Tag and data arrays need not be reset.
  - Reset mid-REQ/FILL abandons the burst. Residual beats after reset are ignored since the FSM is in IDLE.
  - Outputs while in reset: IC_STALL=1, instruction=NOP_INSTR.
- Counter width: log2(LINE_WORDS) bits; it never wraps past LINE_WORDS-1 because the FSM leaves FILL on the last beat.

Test Plan:
- Cold miss: reset, release, PC=0x0; MEM_GNT in the first REQ cycle; beats 0x11111111..0x44444444 back-to-back.
  - MEM_REQ=1 with MEM_ADDR=0x0.
  - IC_STALL=1 for exactly 7 cycles.
  - Then instruction=0x11111111, and PC=0xC gives 0x44444444 with no stall.
- Hit/conflict: after the line at 0x0 is filled, PC=0x100 (same index 0, tag 1).
  - Miss, MEM_ADDR=0x100, refill.
  - Returning to PC=0x0 misses again (direct-mapped eviction).
- Handshake stretch: MEM_GNT delayed 3 cycles, with MEM_RVALID gaps between beats.
  - MEM_REQ held steady with a constant address until the grant.
  - Beats land at offsets 0..3 in order; IC_STALL=1 throughout; NOP_INSTR is output meanwhile.
- Flush mid-fill: assert IC_FLUSH during the second beat of a refill for PC=0x40.
  - Burst completes and the FSM returns to IDLE.
  - Line 4 stays invalid and PC=0x40 misses again.
  - Previously valid lines are also invalid.
- Reset mid-fill: RESET=0 after 2 beats, then RESET=1 with PC=0x40.
  - MEM_REQ=0 during reset; stray MEM_RVALID beats are ignored.
  - A fresh miss issues MEM_REQ with MEM_ADDR=0x40, and a full refill yields the correct data.
- Misaligned low bits: PC=0x6 after the line at 0x0 is filled → returns word 1 (PC[1:0] ignored), no stall.

Source files
------------

// File: rtl/instr_cache_ctrl_if.sv
// Fetch-side lookup and refill memory bus of the instruction cache.
// slave: the cache itself; master: the fetch stage plus backing memory.
interface instr_cache_ctrl_if;
    logic [63:0] PC;
    logic        IC_FLUSH;
    logic [31:0] instruction;
    logic        IC_STALL;
    logic        MEM_REQ;
    logic [63:0] MEM_ADDR;
    logic        MEM_GNT;
    logic        MEM_RVALID;
    logic [31:0] MEM_RDATA;

    modport slave (
        input  PC, IC_FLUSH, MEM_GNT, MEM_RVALID, MEM_RDATA,
        output instruction, IC_STALL, MEM_REQ, MEM_ADDR
    );

    modport master (
        output PC, IC_FLUSH, MEM_GNT, MEM_RVALID, MEM_RDATA,
        input  instruction, IC_STALL, MEM_REQ, MEM_ADDR
    );
endinterface

// File: rtl/instr_cache_ctrl.sv
// Direct-mapped instruction cache with a request/grant/beat refill controller.
// Lookup is combinational from PC; a miss stalls fetch until the line is installed.
module instr_cache_ctrl #(
    parameter int          LINE_WORDS = 4,
    parameter int          NUM_LINES  = 16,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input logic                 CLK,
    input logic                 RESET,
    instr_cache_ctrl_if.slave   bus
);
    localparam int BW  = $clog2(LINE_WORDS);
    localparam int OFF = BW + 2;
    localparam int IW  = $clog2(NUM_LINES);
    localparam int TW  = 64 - OFF - IW;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    state_t                                    state;
    logic [NUM_LINES-1:0]                      valid_q;
    logic [NUM_LINES-1:0][TW-1:0]              tag_q;
    logic [NUM_LINES-1:0][LINE_WORDS-1:0][31:0] data_q;
    logic [63:0]                               miss_addr;
    logic                                      discard;
    logic [BW-1:0]                             beat;
    logic                                      mem_req;

    logic [IW-1:0] pc_idx;
    logic [BW-1:0] pc_word;
    logic [TW-1:0] pc_tag;
    logic [IW-1:0] miss_idx;
    logic [TW-1:0] miss_tag;
    logic          hit;
    logic          unused_bits;

    assign pc_idx   = bus.PC[OFF+IW-1:OFF];
    assign pc_word  = bus.PC[OFF-1:2];
    assign pc_tag   = bus.PC[63:OFF+IW];
    assign miss_idx = miss_addr[OFF+IW-1:OFF];
    assign miss_tag = miss_addr[63:OFF+IW];
    // Byte offset within a word and the always-zero line offset carry no information.
    assign unused_bits = ^{bus.PC[1:0], miss_addr[OFF-1:0]};

    // Lookup only counts in IDLE and out of reset, so DONE and reset always stall.
    assign hit = RESET && (state == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

    assign bus.IC_STALL    = !hit;
    assign bus.instruction = hit ? data_q[pc_idx][pc_word] : NOP_INSTR;
    assign bus.MEM_REQ     = mem_req;
    assign bus.MEM_ADDR    = miss_addr;

    // Refill FSM plus tag/data/valid array updates; flush clears valids last so it wins.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= IDLE;
            valid_q   <= '0;
            discard   <= 1'b0;
            beat      <= '0;
            mem_req   <= 1'b0;
            miss_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        miss_addr <= {bus.PC[63:OFF], {OFF{1'b0}}};
                        mem_req   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.IC_FLUSH) discard <= 1'b1;
                    if (bus.MEM_GNT) begin
                        mem_req <= 1'b0;
                        beat    <= '0;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (bus.IC_FLUSH) discard <= 1'b1;
                    if (bus.MEM_RVALID) begin
                        data_q[miss_idx][beat] <= bus.MEM_RDATA;
                        beat                   <= beat + 1'b1;
                        if (beat == LAST_BEAT) state <= DONE;
                    end
                end
                DONE: begin
                    // A flush in this cycle is covered by the valid clear below.
                    tag_q[miss_idx] <= miss_tag;
                    if (!discard) valid_q[miss_idx] <= 1'b1;
                    discard <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (bus.IC_FLUSH) valid_q <= '0;
        end
    end
endmodule

// File: tb/tb_instr_cache_ctrl.sv
// Scoreboard bench: fetch stimulus pushes expected instructions and refill
// addresses; a monitor and a memory responder pop and compare independently.
module tb_instr_cache_ctrl;
    localparam int          LW  = 4;
    localparam int          NL  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          LINE_BYTES = LW * 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_q = 1'b0;

    instr_cache_ctrl_if bus();

    instr_cache_ctrl #(.LINE_WORDS(LW), .NUM_LINES(NL), .NOP_INSTR(NOP)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rst;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [63:0] addr_q[$];

    // responder controls (written by stimulus only)
    bit fast      = 1'b1;
    bit gaps      = 1'b0;
    bit rand_mode = 1'b0;
    int gnt_delay = 0;
    int flush_on_burst = -1;
    // responder status (written by responder only)
    int bursts     = 0;
    int beats_sent = 0;

    // reference model: which line each index holds
    bit          m_valid[NL];
    logic [63:0] m_tag[NL];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        w = a >> 2;
        if (w < 4) return 32'h1111_1111 * (w[31:0] + 32'd1);
        return (w[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endfunction

    // Monitor: reset outputs, NOP while stalled, scoreboard pop on a valid instruction.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("reset_stall", bus.IC_STALL, 1);
                chk("reset_nop", bus.instruction, NOP);
                if (!rst_q) begin
                    chk("reset_mem_req", bus.MEM_REQ, 0);
                    chk("reset_mem_addr", bus.MEM_ADDR, 0);
                end
            end else if (bus.IC_STALL) begin
                chk("stall_nop", bus.instruction, NOP);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("instr", bus.instruction, e);
            end
        end
    end

    // Memory responder: grant after a delay, then LW beats with optional gaps.
    initial begin
        logic [63:0] a;
        int d, fb;
        bus.MEM_GNT = 1'b0; bus.MEM_RVALID = 1'b0; bus.MEM_RDATA = '0; bus.IC_FLUSH = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!(rst && bus.MEM_REQ)) continue;
            bursts++;
            fb = (bursts == flush_on_burst) ? 1 : -1;
            a = bus.MEM_ADDR;
            if (addr_q.size() == 0) chk("unexpected_req", a, 64'hDEAD);
            else chk("mem_addr", a, addr_q.pop_front());
            d = rand_mode ? int'($urandom_range(0, 3)) : gnt_delay;
            for (int i = 0; i < d; i++) begin
                @(posedge clk); #1;
                chk("req_held", bus.MEM_REQ, 1);
                chk("req_addr_stable", bus.MEM_ADDR, a);
            end
            bus.MEM_GNT = 1'b1;
            @(posedge clk); #1;
            bus.MEM_GNT = 1'b0;
            if (rst) chk("req_drop", bus.MEM_REQ, 0);
            for (int b = 0; b < LW; b++) begin
                if (gaps || rand_mode) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                bus.MEM_RVALID = 1'b1;
                bus.MEM_RDATA  = mem_word(a + 64'(b * 4));
                bus.IC_FLUSH   = (b == fb);
                @(posedge clk); #1;
                bus.MEM_RVALID = 1'b0;
                bus.IC_FLUSH   = 1'b0;
                beats_sent++;
            end
        end
    end

    task automatic issue(input logic [63:0] pc, output bit miss);
        logic [63:0] line, idx, tag;
        @(posedge clk); #1;
        bus.PC = pc;
        rst    = 1'b1;
        line = pc / LINE_BYTES;
        idx  = line % NL;
        tag  = line / NL;
        miss = !(m_valid[idx] && m_tag[idx] == tag);
        exp_q.push_back(mem_word(pc & ~64'h3));
        if (miss) begin
            addr_q.push_back(line * LINE_BYTES);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
        end
    endtask

    task automatic wait_done(input int exact, input int minimum);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            if (bus.IC_STALL) n++;
        end while (bus.IC_STALL && n < 400);
        if (n >= 400) chk("fetch_timeout", n, 0);
        else if (exact >= 0) chk("stall_cycles", n, exact);
        else chk("stall_min", (n >= minimum), 1);
    endtask

    task automatic fetch(input logic [63:0] pc);
        bit miss;
        issue(pc, miss);
        if (!miss) wait_done(0, 0);
        else if (fast) wait_done(LW + 3, 0);
        else wait_done(-1, LW + 3);
    endtask

    initial begin
        bit miss;
        int base;
        logic [63:0] pc;
        bus.PC = '0;
        model_clear();
        repeat (3) @(posedge clk);

        // cold miss, back-to-back hits, misaligned low bits
        fetch(64'h0);
        fetch(64'hC);
        fetch(64'h4);
        fetch(64'h6);
        fetch(64'h8);

        // direct-mapped conflict on index 0
        fetch(64'h100);
        fetch(64'h0);
        fetch(64'h104);

        // delayed grant and beat gaps
        fast = 1'b0; gaps = 1'b1; gnt_delay = 3;
        fetch(64'h200);
        fetch(64'h204);
        fetch(64'h208);
        fetch(64'h20C);
        fast = 1'b1; gaps = 1'b0; gnt_delay = 0;

        // flush during the second beat: line refilled twice, other lines dropped
        fetch(64'h10);
        flush_on_burst = bursts + 1;
        issue(64'h40, miss);
        addr_q.push_back(64'h40);
        model_clear();
        m_valid[4] = 1'b1; m_tag[4] = 64'h0;
        wait_done(-1, 2 * (LW + 3));
        flush_on_burst = -1;
        fetch(64'h10);
        fetch(64'h200);
        fetch(64'h44);

        // reset in the middle of a fill
        fast = 1'b0;
        base = beats_sent;
        issue(64'h440, miss);
        for (int i = 0; i < 100 && beats_sent < base + 2; i++) @(negedge clk);
        chk("two_beats_before_reset", (beats_sent >= base + 2), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_clear();
        repeat (4) @(posedge clk);
        fetch(64'h40);
        fetch(64'h48);
        fetch(64'h4C);

        // randomized traffic
        rand_mode = 1'b1;
        for (int i = 0; i < 80; i++) begin
            pc = 64'($urandom_range(0, 3)) * 256 + 64'($urandom_range(0, NL - 1)) * LINE_BYTES
               + 64'($urandom_range(0, LW - 1)) * 4 + 64'($urandom_range(0, 3));
            fetch(pc);
        end

        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        chk("addr_q_drained", addr_q.size(), 0);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
